// File: rtl/command_deserializer.sv
// command_deserializer
//   Collects a byte-stream command frame from an AXI-Stream style host port
//   into a wide command word. Byte 0 is the header; it selects the expected
//   frame length. A well-formed frame is held on command_o until the consumer
//   accepts it. A malformed frame is dropped and reported with a one-cycle
//   frame_err_o pulse.
// Ports:
//   clk, arst        clock (rising edge), asynchronous active-high reset
//   s_axis_tdata     host byte
//   s_axis_tvalid    byte valid
//   s_axis_tready    byte accepted when tvalid & tready (low while holding)
//   s_axis_tlast     last byte of frame
//   command_o        assembled command, zero unless command_valid_o
//   command_valid_o  command available
//   command_ready_i  consumer accepts command
//   frame_err_o      one-cycle pulse on a discarded frame
module command_deserializer #(
  parameter int                    COMMAND_WIDTH   = 268,
  parameter int                    HEADER_WIDTH    = 8,
  parameter logic [HEADER_WIDTH-1:0] START_HEADER    = 8'h01,
  parameter logic [HEADER_WIDTH-1:0] STOP_HEADER     = 8'h02,
  parameter logic [HEADER_WIDTH-1:0] CONTINUE_HEADER = 8'h03,
  parameter logic [HEADER_WIDTH-1:0] ABORT_HEADER    = 8'h04,
  parameter int                    LONG_LEN        = 34,
  parameter int                    SHORT_LEN       = 10,
  parameter int                    ABORT_LEN       = 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [COMMAND_WIDTH-1:0] command_o,
  output logic                     command_valid_o,
  input  logic                     command_ready_i,
  output logic                     frame_err_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP, HOLD} state_t;

  state_t                   state, state_d;
  logic [5:0]               cnt, cnt_d, cnt_inc;
  logic [HEADER_WIDTH-1:0]  hdr, hdr_d;
  logic [COMMAND_WIDTH-1:0] shadow, shadow_d, shadow_wr;
  logic                     err_q, err_d;
  logic                     rdy_q;
  logic                     acc;
  logic [5:0]               byte_idx;
  logic [5:0]               len_new, len_cur;

  // Expected frame length for a header; 0 marks an unknown header.
  function automatic logic [5:0] exp_len(input logic [HEADER_WIDTH-1:0] h);
    if (h == START_HEADER)                             return 6'(LONG_LEN);
    else if (h == STOP_HEADER || h == CONTINUE_HEADER) return 6'(SHORT_LEN);
    else if (h == ABORT_HEADER)                        return 6'(ABORT_LEN);
    else                                               return 6'd0;
  endfunction

  assign acc     = s_axis_tvalid & s_axis_tready;
  assign cnt_inc = (cnt == 6'h3f) ? cnt : cnt + 6'd1;
  assign len_new = exp_len(s_axis_tdata[HEADER_WIDTH-1:0]);
  assign len_cur = exp_len(hdr);

  // Byte n lands at [8n+7:8n]; bits past COMMAND_WIDTH simply have no home.
  // In IDLE the write starts from a zero base so unreceived bytes read 0.
  always_comb begin
    byte_idx  = (state == IDLE) ? 6'd0 : cnt;
    shadow_wr = (state == IDLE) ? '0 : shadow;
    for (int i = 0; i < COMMAND_WIDTH; i++)
      if (byte_idx == 6'(i / 8)) shadow_wr[i] = s_axis_tdata[i % 8];
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    hdr_d    = hdr;
    shadow_d = shadow;
    err_d    = 1'b0;
    case (state)
      IDLE: if (acc) begin
        hdr_d    = s_axis_tdata[HEADER_WIDTH-1:0];
        cnt_d    = 6'd1;
        shadow_d = shadow_wr;
        if (len_new == 6'd0) begin
          if (s_axis_tlast) err_d = 1'b1;
          else              state_d = DROP;
        end else if (s_axis_tlast) begin
          if (len_new == 6'd1) state_d = HOLD;
          else                 err_d   = 1'b1;
        end else if (len_new == 6'd1) begin
          state_d = DROP;
        end else begin
          state_d = COLLECT;
        end
      end
      COLLECT: if (acc) begin
        cnt_d    = cnt_inc;
        shadow_d = shadow_wr;
        if (s_axis_tlast) begin
          if (cnt_inc == len_cur) state_d = HOLD;
          else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_inc == len_cur) begin
          state_d = DROP;
        end
      end
      DROP: if (acc && s_axis_tlast) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      HOLD: if (command_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= IDLE;
      cnt    <= '0;
      hdr    <= '0;
      shadow <= '0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      hdr    <= hdr_d;
      shadow <= shadow_d;
      err_q  <= err_d;
      rdy_q  <= 1'b1;
    end
  end

  // rdy_q keeps tready low during reset and opens it one clock after release.
  assign s_axis_tready   = rdy_q && (state != HOLD);
  assign command_valid_o = (state == HOLD);
  assign command_o       = (state == HOLD) ? shadow : '0;
  assign frame_err_o     = err_q;

endmodule

// File: tb/tb_command_deserializer.sv
module tb_command_deserializer;

  localparam int W = 268;

  logic         clk = 1'b0;
  logic         arst;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [W-1:0] command_o;
  logic         command_valid_o;
  logic         command_ready_i;
  logic         frame_err_o;

  int n_cmp = 0;
  int n_err = 0;

  command_deserializer dut (
    .clk             (clk),
    .arst            (arst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .command_o       (command_o),
    .command_valid_o (command_valid_o),
    .command_ready_i (command_ready_i),
    .frame_err_o     (frame_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand model of a frame: header, then bytes start, start+1, ... (n bytes total).
  function automatic logic [W-1:0] build(input logic [7:0] h, input logic [7:0] start, input int n);
    logic [271:0] t;
    logic [7:0]   b;
    t = '0;
    t[7:0] = h;
    for (int k = 1; k < n; k++) begin
      b = start + 8'(k - 1);
      t[8*k +: 8] = b;
    end
    return t[W-1:0];
  endfunction

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    n = 0;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("tready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] start, input int n, input logic with_last);
    for (int k = 0; k < n; k++)
      send_byte((k == 0) ? h : start + 8'(k - 1), with_last && (k == n - 1));
  endtask

  task automatic release_cmd(input string tag);
    command_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    command_ready_i = 1'b0;
    check({tag, "_valid_after"}, command_valid_o, 1'b0);
    check({tag, "_cmd_after"}, command_o, '0);
  endtask

  logic [W-1:0] exp_cmd;

  initial begin
    arst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    command_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_valid", command_valid_o, 1'b0);
    check("rst_cmd", command_o, '0);
    check("rst_err", frame_err_o, 1'b0);
    arst = 1'b0;
    @(negedge clk);
    check("rst_tready_after", s_axis_tready, 1'b1);

    // START frame, 34 bytes 01,10..30
    send_frame(8'h01, 8'h10, 34, 1'b1);
    exp_cmd = build(8'h01, 8'h10, 34);
    check("start_valid", command_valid_o, 1'b1);
    check("start_b0", command_o[7:0], 8'h01);
    check("start_b1", command_o[15:8], 8'h10);
    check("start_top", command_o[267:264], 4'h0);
    check("start_cmd", command_o, exp_cmd);
    check("start_tready", s_axis_tready, 1'b0);
    release_cmd("start");

    // STOP frame held for 5 cycles
    send_frame(8'h02, 8'hA1, 10, 1'b1);
    exp_cmd = build(8'h02, 8'hA1, 10);
    for (int c = 0; c < 5; c++) begin
      check("stop_hold_cmd", command_o, exp_cmd);
      check("stop_hold_tready", s_axis_tready, 1'b0);
      @(negedge clk);
    end
    release_cmd("stop");

    // ABORT single byte
    send_byte(8'h04, 1'b1);
    check("abort_valid", command_valid_o, 1'b1);
    check("abort_cmd", command_o, W'(8'h04));
    release_cmd("abort");

    // STOP header, tlast at byte 6 -> error
    send_frame(8'h02, 8'h20, 6, 1'b1);
    check("short_err", frame_err_o, 1'b1);
    check("short_valid", command_valid_o, 1'b0);
    @(negedge clk);
    check("short_err_end", frame_err_o, 1'b0);
    send_frame(8'h03, 8'h61, 10, 1'b1);
    check("cont_valid", command_valid_o, 1'b1);
    check("cont_cmd", command_o, build(8'h03, 8'h61, 10));
    release_cmd("cont");

    // Unknown header, 12 bytes
    send_frame(8'h55, 8'h70, 12, 1'b1);
    check("bad_err", frame_err_o, 1'b1);
    check("bad_valid", command_valid_o, 1'b0);
    @(negedge clk);
    check("bad_err_end", frame_err_o, 1'b0);

    // START frame of 40 bytes -> DROP after 34, error after 40
    send_frame(8'h01, 8'h10, 34, 1'b0);
    check("long_err_34", frame_err_o, 1'b0);
    check("long_valid_34", command_valid_o, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(8'hE0 + 8'(k), k == 5);
    check("long_err", frame_err_o, 1'b1);
    check("long_valid", command_valid_o, 1'b0);
    @(negedge clk);
    check("long_err_end", frame_err_o, 1'b0);

    // Reset in the middle of a START frame
    send_frame(8'h01, 8'h10, 20, 1'b0);
    arst = 1'b1;
    #1;
    check("mid_rst_tready", s_axis_tready, 1'b0);
    check("mid_rst_valid", command_valid_o, 1'b0);
    check("mid_rst_cmd", command_o, '0);
    check("mid_rst_err", frame_err_o, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("post_rst_err", frame_err_o, 1'b0);
    check("post_rst_tready", s_axis_tready, 1'b1);
    send_frame(8'h01, 8'h40, 34, 1'b1);
    check("post_rst_valid", command_valid_o, 1'b1);
    check("post_rst_cmd", command_o, build(8'h01, 8'h40, 34));
    release_cmd("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/command_deserializer.md
COMMAND_DESERIALIZER -- requirements
Module: command_deserializer

Interface
REQ-001 SHALL have parameter COMMAND_WIDTH, default 268, giving the width of the assembled command word.
REQ-002 SHALL have parameter HEADER_WIDTH, default 8, giving the header field width in bits [HEADER_WIDTH-1:0].
REQ-003 SHALL have parameters START_HEADER 8'h01, STOP_HEADER 8'h02, CONTINUE_HEADER 8'h03 and ABORT_HEADER 8'h04, which are the valid header codes.
REQ-004 SHALL have parameters LONG_LEN 34 (START frame byte count), SHORT_LEN 10 (STOP/CONTINUE frame byte count) and ABORT_LEN 1.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 arst  input  1  asynchronous reset, active-high.
REQ-007 s_axis_tdata  input  8  host command byte.
REQ-008 s_axis_tvalid  input  1  byte valid.
REQ-009 s_axis_tready  output  1  byte accepted when tvalid & tready.
REQ-010 s_axis_tlast  input  1  last byte of frame.
REQ-011 command_o  output  COMMAND_WIDTH  assembled command; zero unless command_valid_o=1.
REQ-012 command_valid_o  output  1  command available.
REQ-013 command_ready_i  input  1  consumer accepts command.
REQ-014 frame_err_o  output  1  one-cycle pulse on a discarded frame.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DROP and HOLD.
REQ-016 SHALL assert s_axis_tready in IDLE, COLLECT and DROP, and SHALL deassert it in HOLD.
REQ-017 SHALL place byte n of a frame (n=0 first) at bits [8n+7:8n] of the shadow register, and SHALL discard bits at or above COMMAND_WIDTH.
REQ-018 SHALL clear the shadow register to zero on entry to COLLECT, so that bytes not received read as zero.
REQ-019 IDLE, on an accepted byte: SHALL store it as the header, set byte count to 1, and go to COLLECT; if tlast is also set, SHALL evaluate the end of frame in the same cycle per REQ-021.
REQ-020 If the header is not one of the four codes, SHALL go to DROP (or to IDLE with frame_err_o if tlast is set), and SHALL neither accept the frame nor present it.
REQ-021 End of frame (accepted byte with tlast): if the final count equals the expected length for the header, SHALL go to HOLD; otherwise SHALL pulse frame_err_o and return to IDLE.
REQ-022 COLLECT: if the count reaches the expected length without tlast, SHALL go to DROP.
REQ-023 DROP: SHALL accept and discard bytes until tlast, then pulse frame_err_o and go to IDLE.
REQ-024 HOLD: SHALL drive command_o from the shadow register and command_valid_o=1, both stable until command_ready_i=1.
REQ-025 HOLD with command_ready_i=1: SHALL go to IDLE on the next edge, after which command_o=0 and command_valid_o=0.
REQ-026 SHALL treat an ABORT frame (1 byte, tlast) as a valid command of header only.
REQ-027 SHALL make the byte counter 6 bits wide, saturating at 63.
REQ-028 SHALL register frame_err_o, asserting it for exactly one cycle after the offending tlast byte is accepted.
REQ-029 Latency: SHALL assert command_valid_o on the cycle after the tlast byte is accepted.
REQ-030 SHALL ignore s_axis_tlast when s_axis_tvalid is low.

Reset
REQ-031 arst SHALL force state IDLE, count 0, shadow 0, command_o 0, command_valid_o 0, frame_err_o 0 and s_axis_tready 0 while asserted; tready SHALL be 1 from the first clock after release.
REQ-032 arst mid-frame or in HOLD SHALL discard the partial or pending command without asserting frame_err_o.

Verification
REQ-033 START frame 8'h01 followed by 33 bytes 8'h10..8'h30, tlast on the 34th byte -> command_valid_o next cycle, command_o[7:0]=8'h01, command_o[15:8]=8'h10, bits [267:264]=4'h0 (high nibble of 8'h30 truncated).
REQ-034 STOP frame of 10 bytes with command_ready_i held low for 5 cycles -> command_o stable, tready=0 for those 5 cycles; after ready, command_o=0 the next cycle.
REQ-035 Single byte 8'h04 with tlast -> valid command, command_o=268'h04.
REQ-036 STOP header with tlast on byte 6 -> frame_err_o single pulse, no command_valid_o; a following valid frame is accepted normally.
REQ-037 Header 8'h55 and 12-byte frame -> all bytes accepted, frame_err_o pulse after tlast, no command; START frame of 40 bytes -> DROP after byte 34, error pulse after byte 40.
REQ-038 arst asserted at byte 20 of a START frame -> all outputs 0, no error pulse; a next full frame decodes correctly.
